// File: rtl/fft_bfly_ram.sv
// Working memory for the radix-2 in-place FFT: bit-reversed load, dual-port butterfly access, natural-order unload.
// Ports: load_start/in_* (load), rd_*/wr_* (operands), unload_start/out_* (valid/ready stream), busy.
module fft_bfly_ram #(
  parameter int DATA_W = 29,
  parameter int LOG2N  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  output logic              load_done,
  input  logic              rd_en,
  input  logic [LOG2N-1:0]  rd_adr_a,
  input  logic [LOG2N-1:0]  rd_adr_b,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_re_a,
  output logic [DATA_W-1:0] rd_im_a,
  output logic [DATA_W-1:0] rd_re_b,
  output logic [DATA_W-1:0] rd_im_b,
  input  logic              wr_en,
  input  logic [LOG2N-1:0]  wr_adr_a,
  input  logic [LOG2N-1:0]  wr_adr_b,
  input  logic [DATA_W-1:0] wr_re_a,
  input  logic [DATA_W-1:0] wr_im_a,
  input  logic [DATA_W-1:0] wr_re_b,
  input  logic [DATA_W-1:0] wr_im_b,
  input  logic              unload_start,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic              out_last,
  output logic              busy
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_UNLOAD
  } state_e;

  state_e state_q, state_d;

  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic iss_done_q, iss_done_d;
  logic load_done_q, load_done_d;
  logic rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_re_a_q, rd_re_a_d;
  logic [DATA_W-1:0] rd_im_a_q, rd_im_a_d;
  logic [DATA_W-1:0] rd_re_b_q, rd_re_b_d;
  logic [DATA_W-1:0] rd_im_b_q, rd_im_b_d;

  // two-entry output skid buffer, entry 0 is the head
  logic [1:0][DATA_W-1:0] sk_re_q, sk_re_d;
  logic [1:0][DATA_W-1:0] sk_im_q, sk_im_d;
  logic [1:0] sk_last_q, sk_last_d;
  logic [1:0] sk_cnt_q, sk_cnt_d;

  logic [DATA_W-1:0] mem_re [N];
  logic [DATA_W-1:0] mem_im [N];

  logic idle;
  logic ld_we;
  logic [LOG2N-1:0] ld_adr;
  logic rd_go;
  logic wr_go;
  logic push;
  logic pop;
  logic [DATA_W-1:0] byp_re_a, byp_im_a;
  logic [DATA_W-1:0] byp_re_b, byp_im_b;

  function automatic logic [LOG2N-1:0] bitrev(
    input logic [LOG2N-1:0] a
  );
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = a[LOG2N-1-i];
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_LOAD;
        end else if (unload_start) begin
          state_d = S_UNLOAD;
        end
      end
      S_LOAD: begin
        if (in_valid && cnt_q == LAST) begin
          state_d = S_IDLE;
        end
      end
      S_UNLOAD: begin
        if (pop && sk_last_q[0]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idle   = (state_q == S_IDLE);
    ld_we  = (state_q == S_LOAD) && in_valid;
    ld_adr = bitrev(cnt_q);
    rd_go  = idle && rd_en;
    wr_go  = idle && wr_en;
    pop    = (sk_cnt_q != 2'd0) && out_ready;
    push   = (state_q == S_UNLOAD) && !iss_done_q
             && ((sk_cnt_q != 2'd2) || pop);

    cnt_d      = cnt_q;
    iss_done_d = iss_done_q;
    if (ld_we || push) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (push && cnt_q == LAST) begin
      iss_done_d = 1'b1;
    end
    if (idle) begin
      cnt_d      = '0;
      iss_done_d = 1'b0;
    end
    load_done_d = ld_we && (cnt_q == LAST);

    // write-first bypass, port b has priority
    byp_re_a = mem_re[rd_adr_a];
    byp_im_a = mem_im[rd_adr_a];
    byp_re_b = mem_re[rd_adr_b];
    byp_im_b = mem_im[rd_adr_b];
    if (wr_go && wr_adr_a == rd_adr_a) begin
      byp_re_a = wr_re_a;
      byp_im_a = wr_im_a;
    end
    if (wr_go && wr_adr_b == rd_adr_a) begin
      byp_re_a = wr_re_b;
      byp_im_a = wr_im_b;
    end
    if (wr_go && wr_adr_a == rd_adr_b) begin
      byp_re_b = wr_re_a;
      byp_im_b = wr_im_a;
    end
    if (wr_go && wr_adr_b == rd_adr_b) begin
      byp_re_b = wr_re_b;
      byp_im_b = wr_im_b;
    end

    rd_valid_d = rd_go;
    rd_re_a_d  = rd_re_a_q;
    rd_im_a_d  = rd_im_a_q;
    rd_re_b_d  = rd_re_b_q;
    rd_im_b_d  = rd_im_b_q;
    if (rd_go) begin
      rd_re_a_d = byp_re_a;
      rd_im_a_d = byp_im_a;
      rd_re_b_d = byp_re_b;
      rd_im_b_d = byp_im_b;
    end

    sk_re_d   = sk_re_q;
    sk_im_d   = sk_im_q;
    sk_last_d = sk_last_q;
    sk_cnt_d  = sk_cnt_q;
    case ({push, pop})
      2'b11: begin
        if (sk_cnt_q == 2'd1) begin
          sk_re_d[0]   = mem_re[cnt_q];
          sk_im_d[0]   = mem_im[cnt_q];
          sk_last_d[0] = (cnt_q == LAST);
        end else begin
          sk_re_d[0]   = sk_re_q[1];
          sk_im_d[0]   = sk_im_q[1];
          sk_last_d[0] = sk_last_q[1];
          sk_re_d[1]   = mem_re[cnt_q];
          sk_im_d[1]   = mem_im[cnt_q];
          sk_last_d[1] = (cnt_q == LAST);
        end
      end
      2'b01: begin
        sk_re_d[0]   = sk_re_q[1];
        sk_im_d[0]   = sk_im_q[1];
        sk_last_d[0] = sk_last_q[1];
        sk_cnt_d     = sk_cnt_q - 2'd1;
      end
      2'b10: begin
        if (sk_cnt_q == 2'd0) begin
          sk_re_d[0]   = mem_re[cnt_q];
          sk_im_d[0]   = mem_im[cnt_q];
          sk_last_d[0] = (cnt_q == LAST);
        end else begin
          sk_re_d[1]   = mem_re[cnt_q];
          sk_im_d[1]   = mem_im[cnt_q];
          sk_last_d[1] = (cnt_q == LAST);
        end
        sk_cnt_d = sk_cnt_q + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      iss_done_q  <= 1'b0;
      load_done_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_re_a_q   <= '0;
      rd_im_a_q   <= '0;
      rd_re_b_q   <= '0;
      rd_im_b_q   <= '0;
      sk_re_q     <= '0;
      sk_im_q     <= '0;
      sk_last_q   <= '0;
      sk_cnt_q    <= '0;
    end else begin
      cnt_q       <= cnt_d;
      iss_done_q  <= iss_done_d;
      load_done_q <= load_done_d;
      rd_valid_q  <= rd_valid_d;
      rd_re_a_q   <= rd_re_a_d;
      rd_im_a_q   <= rd_im_a_d;
      rd_re_b_q   <= rd_re_b_d;
      rd_im_b_q   <= rd_im_b_d;
      sk_re_q     <= sk_re_d;
      sk_im_q     <= sk_im_d;
      sk_last_q   <= sk_last_d;
      sk_cnt_q    <= sk_cnt_d;
    end
  end

  // storage is not reset; port b lands last so it wins on equal addresses
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem_re[ld_adr] <= in_re;
      mem_im[ld_adr] <= in_im;
    end
    if (wr_go) begin
      mem_re[wr_adr_a] <= wr_re_a;
      mem_im[wr_adr_a] <= wr_im_a;
      mem_re[wr_adr_b] <= wr_re_b;
      mem_im[wr_adr_b] <= wr_im_b;
    end
  end

  assign load_done = load_done_q;
  assign rd_valid  = rd_valid_q;
  assign rd_re_a   = rd_re_a_q;
  assign rd_im_a   = rd_im_a_q;
  assign rd_re_b   = rd_re_b_q;
  assign rd_im_b   = rd_im_b_q;
  assign out_valid = (sk_cnt_q != 2'd0);
  assign out_re    = sk_re_q[0];
  assign out_im    = sk_im_q[0];
  assign out_last  = sk_last_q[0];
  assign busy      = !idle;

endmodule

// File: tb/tb_fft_bfly_ram.sv
// Testbench for fft_bfly_ram: table reads after bit-reversed load, hazards,
// random dual-port traffic against an array model, backpressured unload, resets.
module tb_fft_bfly_ram;

  localparam int DW = 29;
  localparam int LG = 4;
  localparam int N  = 16;

  logic clk, rst_n;
  logic load_start, in_valid, load_done;
  logic [DW-1:0] in_re, in_im;
  logic rd_en, rd_valid;
  logic [LG-1:0] rd_adr_a, rd_adr_b;
  logic [DW-1:0] rd_re_a, rd_im_a, rd_re_b, rd_im_b;
  logic wr_en;
  logic [LG-1:0] wr_adr_a, wr_adr_b;
  logic [DW-1:0] wr_re_a, wr_im_a, wr_re_b, wr_im_b;
  logic unload_start, out_valid, out_ready, out_last, busy;
  logic [DW-1:0] out_re, out_im;

  fft_bfly_ram #(.DATA_W(DW), .LOG2N(LG)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .in_valid(in_valid),
    .in_re(in_re), .in_im(in_im), .load_done(load_done),
    .rd_en(rd_en), .rd_adr_a(rd_adr_a), .rd_adr_b(rd_adr_b),
    .rd_valid(rd_valid),
    .rd_re_a(rd_re_a), .rd_im_a(rd_im_a),
    .rd_re_b(rd_re_b), .rd_im_b(rd_im_b),
    .wr_en(wr_en), .wr_adr_a(wr_adr_a), .wr_adr_b(wr_adr_b),
    .wr_re_a(wr_re_a), .wr_im_a(wr_im_a),
    .wr_re_b(wr_re_b), .wr_im_b(wr_im_b),
    .unload_start(unload_start), .out_valid(out_valid),
    .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_last(out_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] m_re [N];
  logic [DW-1:0] m_im [N];

  typedef struct {
    logic [LG-1:0] adr;
    int re;
    int im;
  } rvec_t;
  rvec_t tab [6];

  function automatic logic [DW-1:0] d(input int v);
    return DW'(v);
  endfunction

  function automatic int brev(input int k);
    int r = 0;
    for (int i = 0; i < LG; i++) r = r * 2 + ((k >> i) & 1);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    load_start = 0; in_valid = 0; in_re = '0; in_im = '0;
    rd_en = 0; rd_adr_a = '0; rd_adr_b = '0;
    wr_en = 0; wr_adr_a = '0; wr_adr_b = '0;
    wr_re_a = '0; wr_im_a = '0; wr_re_b = '0; wr_im_b = '0;
    unload_start = 0; out_ready = 0;
  endtask

  task automatic feed(input int k0, input int k1, input int off);
    for (int k = k0; k <= k1; k++) begin
      in_valid = 1; in_re = d(k + off); in_im = d(-(k + off));
      tick();
      m_re[brev(k)] = d(k + off);
      m_im[brev(k)] = d(-(k + off));
      if (k < N - 1) chk("load_done_early", 64'(load_done), 0);
    end
    in_valid = 0;
  endtask

  task automatic full_load();
    load_start = 1;
    tick();
    load_start = 0;
    chk("load_busy", 64'(busy), 1);
    feed(0, N - 1, 0);
    chk("load_done_pulse", 64'(load_done), 1);
    chk("load_busy_end", 64'(busy), 0);
    tick();
    chk("load_done_once", 64'(load_done), 0);
  endtask

  task automatic rd(input int a, input int b, input string nm);
    rd_en = 1; rd_adr_a = LG'(a); rd_adr_b = LG'(b);
    tick();
    rd_en = 0;
    chk({nm, "_valid"}, 64'(rd_valid), 1);
    chk({nm, "_re_a"}, 64'(rd_re_a), 64'(m_re[a]));
    chk({nm, "_im_a"}, 64'(rd_im_a), 64'(m_im[a]));
    chk({nm, "_re_b"}, 64'(rd_re_b), 64'(m_re[b]));
    chk({nm, "_im_b"}, 64'(rd_im_b), 64'(m_im[b]));
  endtask

  task automatic tab_reads();
    for (int i = 0; i < 6; i++) begin
      rd_en = 1; rd_adr_a = tab[i].adr; rd_adr_b = tab[5 - i].adr;
      tick();
      rd_en = 0;
      chk("tab_valid", 64'(rd_valid), 1);
      chk("tab_re_a", 64'(rd_re_a), 64'(d(tab[i].re)));
      chk("tab_im_a", 64'(rd_im_a), 64'(d(tab[i].im)));
      chk("tab_re_b", 64'(rd_re_b), 64'(d(tab[5 - i].re)));
      chk("tab_im_b", 64'(rd_im_b), 64'(d(tab[5 - i].im)));
    end
    tick();
    chk("tab_valid_drop", 64'(rd_valid), 0);
  endtask

  task automatic mwr(input int a, input int ra, input int ia,
                     input int b, input int rb, input int ib);
    wr_en = 1;
    wr_adr_a = LG'(a); wr_re_a = d(ra); wr_im_a = d(ia);
    wr_adr_b = LG'(b); wr_re_b = d(rb); wr_im_b = d(ib);
  endtask

  task automatic mwr_model(input int a, input int ra, input int ia,
                           input int b, input int rb, input int ib);
    m_re[a] = d(ra); m_im[a] = d(ia);
    m_re[b] = d(rb); m_im[b] = d(ib);
  endtask

  initial begin
    int exp_i, cyc;
    logic held_v, held_last;
    logic [DW-1:0] held_re, held_im;
    int ra, rb, wa, wb;
    logic we, re;
    logic [DW-1:0] v0, v1, v2, v3;

    tab[0] = '{4'd8, 1, -1};
    tab[1] = '{4'd3, 12, -12};
    tab[2] = '{4'd15, 15, -15};
    tab[3] = '{4'd0, 0, 0};
    tab[4] = '{4'd1, 8, -8};
    tab[5] = '{4'd4, 2, -2};

    clr_in();
    rst_n = 0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_load_done", 64'(load_done), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_rd_valid", 64'(rd_valid), 0);
    chk("rst_out_re", 64'(out_re), 0);
    chk("rst_rd_re_a", 64'(rd_re_a), 0);
    rst_n = 1;
    tick();

    full_load();
    tab_reads();

    mwr(2, 100, 7, 9, -5, 3);
    tick();
    wr_en = 0;
    mwr_model(2, 100, 7, 9, -5, 3);
    rd(9, 2, "dual");

    mwr(4, 11, 22, 10, 33, 44);
    rd_en = 1; rd_adr_a = 4'd4; rd_adr_b = 4'd10;
    tick();
    wr_en = 0; rd_en = 0;
    mwr_model(4, 11, 22, 10, 33, 44);
    chk("byp_re_a", 64'(rd_re_a), 64'(d(11)));
    chk("byp_im_a", 64'(rd_im_a), 64'(d(22)));
    chk("byp_re_b", 64'(rd_re_b), 64'(d(33)));
    chk("byp_im_b", 64'(rd_im_b), 64'(d(44)));

    mwr(6, 1, 1, 6, 2, 2);
    rd_en = 1; rd_adr_a = 4'd6; rd_adr_b = 4'd4;
    tick();
    wr_en = 0; rd_en = 0;
    chk("byp_bwin_re", 64'(rd_re_a), 64'(d(2)));
    chk("byp_bwin_im", 64'(rd_im_a), 64'(d(2)));
    mwr_model(6, 1, 1, 6, 2, 2);
    rd(6, 6, "bwin_later");

    for (int it = 0; it < 40; it++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      if (it[0]) begin
        ra = $urandom_range(0, 3); rb = $urandom_range(0, 3);
        wa = $urandom_range(0, 3); wb = $urandom_range(0, 3);
      end else begin
        ra = $urandom_range(0, N - 1); rb = $urandom_range(0, N - 1);
        wa = $urandom_range(0, N - 1); wb = $urandom_range(0, N - 1);
      end
      v0 = DW'($urandom); v1 = DW'($urandom);
      v2 = DW'($urandom); v3 = DW'($urandom);
      wr_en = we; wr_adr_a = LG'(wa); wr_adr_b = LG'(wb);
      wr_re_a = v0; wr_im_a = v1; wr_re_b = v2; wr_im_b = v3;
      rd_en = re; rd_adr_a = LG'(ra); rd_adr_b = LG'(rb);
      tick();
      if (we) begin
        m_re[wa] = v0; m_im[wa] = v1;
        m_re[wb] = v2; m_im[wb] = v3;
      end
      chk("rnd_valid", 64'(rd_valid), 64'(re));
      if (re) begin
        chk("rnd_re_a", 64'(rd_re_a), 64'(m_re[ra]));
        chk("rnd_im_a", 64'(rd_im_a), 64'(m_im[ra]));
        chk("rnd_re_b", 64'(rd_re_b), 64'(m_re[rb]));
        chk("rnd_im_b", 64'(rd_im_b), 64'(m_im[rb]));
      end
    end
    clr_in();

    for (int j = 0; j < N / 2; j++) begin
      mwr(2 * j, 2 * j, 2 * j, 2 * j + 1, 2 * j + 1, 2 * j + 1);
      tick();
      mwr_model(2 * j, 2 * j, 2 * j, 2 * j + 1, 2 * j + 1, 2 * j + 1);
    end
    wr_en = 0;

    unload_start = 1;
    tick();
    unload_start = 0;
    chk("unl_busy", 64'(busy), 1);
    chk("unl_lat0", 64'(out_valid), 0);
    tick();
    chk("unl_first_valid", 64'(out_valid), 1);
    exp_i = 0; cyc = 0; held_v = 0;
    held_re = '0; held_im = '0; held_last = 0;
    while (exp_i < N && cyc < 200) begin
      if (held_v) begin
        chk("unl_hold_v", 64'(out_valid), 1);
        chk("unl_hold_re", 64'(out_re), 64'(held_re));
        chk("unl_hold_im", 64'(out_im), 64'(held_im));
        chk("unl_hold_last", 64'(out_last), 64'(held_last));
      end
      out_ready = (cyc % 3 == 0);
      if (out_valid && out_ready) begin
        chk("unl_re", 64'(out_re), 64'(d(exp_i)));
        chk("unl_im", 64'(out_im), 64'(d(exp_i)));
        chk("unl_last", 64'(out_last), 64'(exp_i == N - 1));
        exp_i++;
        held_v = 0;
      end else if (out_valid) begin
        held_v = 1; held_re = out_re; held_im = out_im;
        held_last = out_last;
      end else begin
        held_v = 0;
      end
      tick();
      cyc++;
    end
    out_ready = 0;
    chk("unl_count", 64'(exp_i), 64'(N));
    chk("unl_end_valid", 64'(out_valid), 0);
    chk("unl_end_busy", 64'(busy), 0);

    unload_start = 1;
    tick();
    unload_start = 0;
    tick();
    out_ready = 1;
    for (int i = 0; i < N; i++) begin
      chk("thr_valid", 64'(out_valid), 1);
      chk("thr_re", 64'(out_re), 64'(d(i)));
      tick();
    end
    out_ready = 0;
    chk("thr_end_valid", 64'(out_valid), 0);
    chk("thr_end_busy", 64'(busy), 0);

    load_start = 1; unload_start = 1;
    tick();
    load_start = 0; unload_start = 0;
    chk("both_busy", 64'(busy), 1);
    feed(0, 4, 100);
    rd_en = 1; rd_adr_a = 4'd5; rd_adr_b = 4'd0;
    mwr(5, 777, 777, 5, 777, 777);
    unload_start = 1;
    tick();
    clr_in();
    chk("ign_rd_valid", 64'(rd_valid), 0);
    chk("ign_out_valid", 64'(out_valid), 0);
    chk("ign_busy", 64'(busy), 1);
    tick();
    chk("ign_rd_valid2", 64'(rd_valid), 0);
    chk("ign_out_valid2", 64'(out_valid), 0);
    feed(5, N - 1, 100);
    chk("ign_load_done", 64'(load_done), 1);
    tick();
    chk("ign_idle_valid", 64'(out_valid), 0);
    rd(5, 0, "ign_mem");

    load_start = 1;
    tick();
    load_start = 0;
    feed(0, 6, 50);
    rst_n = 0;
    #1;
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_done", 64'(load_done), 0);
    chk("mid_rst_outv", 64'(out_valid), 0);
    tick();
    chk("mid_rst_done2", 64'(load_done), 0);
    rst_n = 1;
    tick();
    full_load();
    tab_reads();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
